// File: rtl/riscv_store_checker.sv
// Store-stream checker: snoops the core's data-memory write bus and compares every
// store against a programmable table of expected (address, data) pairs.
module riscv_store_checker #(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter int                N_EXP       = 4,
   parameter bit                ORDERED     = 1'b1,
   parameter bit                SCRATCH_EN  = 1'b1,
   parameter logic [ADDR_W-1:0] SCRATCH_ADR = 96,
   parameter int unsigned       TIMEOUT     = 1000,
   localparam int               IDX_W       = (N_EXP > 1) ? $clog2(N_EXP) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] DataAdr,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [ADDR_W-1:0] cfg_adr,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic [IDX_W:0]    cfg_n,
   input  logic              start,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic [1:0]        fail_code,
   output logic [ADDR_W-1:0] fail_adr,
   output logic [DATA_W-1:0] fail_data,
   output logic [IDX_W:0]    match_cnt,
   output logic [31:0]       cycle_cnt
);

   typedef enum logic [1:0] {IDLE, ARMED, PASS, FAIL} stateT;

   localparam logic [IDX_W:0]   NEXP    = (IDX_W+1)'(N_EXP);
   localparam logic [IDX_W:0]   CNT_ONE = (IDX_W+1)'(1);
   localparam logic [IDX_W-1:0] PTR_ONE = IDX_W'(1);
   localparam logic [31:0]      TO_LAST = 32'(TIMEOUT - 1);

   stateT             state;
   logic [ADDR_W-1:0] tblAdr  [N_EXP];
   logic [DATA_W-1:0] tblData [N_EXP];
   logic [N_EXP-1:0]  matched;
   logic [IDX_W-1:0]  ptr;
   logic [IDX_W:0]    nAct;
   logic [IDX_W:0]    nClamp;
   logic [IDX_W-1:0]  candIdx;
   logic              candValid;
   logic              adrHit;
   logic              dataHit;
   logic              isMatch;
   logic              isScratch;
   logic              completes;
   logic              timeoutHit;

   assign nClamp = (cfg_n > NEXP) ? NEXP : cfg_n;

   // Table is deliberately not reset; it is frozen while a run is armed.
   always_ff @(posedge clk) begin
      if (cfg_we && state != ARMED && {1'b0, cfg_idx} < NEXP) begin
         tblAdr[cfg_idx]  <= cfg_adr;
         tblData[cfg_idx] <= cfg_data;
      end
   end

   // Unordered: descending scan so the lowest matching unmatched entry wins.
   always_comb begin
      candValid = 1'b0;
      candIdx   = '0;
      if (ORDERED) begin
         candValid = 1'b1;
         candIdx   = ptr;
      end else begin
         for (int i = N_EXP-1; i >= 0; i--) begin
            if ((IDX_W+1)'(i) < nAct && !matched[i] && DataAdr == tblAdr[i]) begin
               candValid = 1'b1;
               candIdx   = IDX_W'(i);
            end
         end
      end
   end

   assign adrHit     = candValid && (DataAdr == tblAdr[candIdx]);
   assign dataHit    = (WriteData == tblData[candIdx]);
   assign isMatch    = MemWrite && adrHit && dataHit;
   assign isScratch  = SCRATCH_EN && (DataAdr == SCRATCH_ADR);
   assign completes  = isMatch && ((match_cnt + CNT_ONE) == nAct);
   assign timeoutHit = (TIMEOUT != 0) && (cycle_cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         fail_code <= 2'd0;
         fail_adr  <= '0;
         fail_data <= '0;
         match_cnt <= '0;
         cycle_cnt <= '0;
         matched   <= '0;
         ptr       <= '0;
         nAct      <= '0;
      end else begin
         case (state)
            ARMED: begin
               if (cycle_cnt != '1)
                  cycle_cnt <= cycle_cnt + 32'd1;
               if (isMatch) begin
                  matched[candIdx] <= 1'b1;
                  ptr              <= ptr + PTR_ONE;
                  match_cnt        <= match_cnt + CNT_ONE;
               end
               // A completing store beats a same-edge timeout; a failing store keeps its own code.
               if (completes) begin
                  state <= PASS;
                  done  <= 1'b1;
                  pass  <= 1'b1;
               end else if (MemWrite && !isMatch && !isScratch) begin
                  state     <= FAIL;
                  done      <= 1'b1;
                  fail      <= 1'b1;
                  fail_code <= adrHit ? 2'd2 : 2'd1;
                  fail_adr  <= DataAdr;
                  fail_data <= WriteData;
               end else if (timeoutHit) begin
                  state     <= FAIL;
                  done      <= 1'b1;
                  fail      <= 1'b1;
                  fail_code <= 2'd3;
                  fail_adr  <= '0;
                  fail_data <= '0;
               end
            end
            default: begin
               if (start) begin
                  nAct      <= nClamp;
                  matched   <= '0;
                  ptr       <= '0;
                  match_cnt <= '0;
                  cycle_cnt <= '0;
                  fail      <= 1'b0;
                  fail_code <= 2'd0;
                  fail_adr  <= '0;
                  fail_data <= '0;
                  if (nClamp == '0) begin
                     state <= PASS;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end else begin
                     state <= ARMED;
                     done  <= 1'b0;
                     pass  <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_store_checker.sv
// Bench for riscv_store_checker: three instances (ordered, unordered, short timeout)
// share one stimulus stream and are each tracked by a behavioural reference model.
module tb_riscv_store_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, MemWrite, cfg_we, start;
   logic [31:0] DataAdr, WriteData, cfg_adr, cfg_data;
   logic [1:0]  cfg_idx;
   logic [2:0]  cfg_n;

   logic        doneO [3];
   logic        passO [3];
   logic        failO [3];
   logic [1:0]  codeO [3];
   logic [31:0] fadrO [3];
   logic [31:0] fdataO[3];
   logic [2:0]  mcO   [3];
   logic [31:0] ccO   [3];

   // Instance 0: ordered, 1: unordered, 2: ordered with TIMEOUT=20.
   for (genvar g = 0; g < 3; g++) begin : gDut
      riscv_store_checker #(
         .ORDERED (g != 1),
         .TIMEOUT ((g == 2) ? 20 : 1000)
      ) dut (
         .clk       (clk),
         .reset     (reset),
         .MemWrite  (MemWrite),
         .DataAdr   (DataAdr),
         .WriteData (WriteData),
         .cfg_we    (cfg_we),
         .cfg_idx   (cfg_idx),
         .cfg_adr   (cfg_adr),
         .cfg_data  (cfg_data),
         .cfg_n     (cfg_n),
         .start     (start),
         .done      (doneO[g]),
         .pass      (passO[g]),
         .fail      (failO[g]),
         .fail_code (codeO[g]),
         .fail_adr  (fadrO[g]),
         .fail_data (fdataO[g]),
         .match_cnt (mcO[g]),
         .cycle_cnt (ccO[g])
      );
   end

   int nChecks = 0;
   int nFails  = 0;

   // Reference model state; mSt: 0 idle, 1 armed, 2 pass, 3 fail.
   int          mSt   [3];
   int          mNact [3];
   logic [3:0]  mUsed [3];
   int          mMc   [3];
   logic [31:0] mCc   [3];
   int          mCode [3];
   logic [31:0] mFadr [3];
   logic [31:0] mFdata[3];
   logic [31:0] mTA   [3][4];
   logic [31:0] mTD   [3][4];

   typedef struct {
      logic [31:0] a0, d0, a1, d1;
      int codeA, mcA; bit passA;
      int codeB, mcB; bit passB;
   } vecT;
   vecT vecs[9];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic modelStep(int k);
      int          cand;
      int          n;
      logic [31:0] cc;
      int unsigned tout;
      tout = (k == 2) ? 20 : 1000;
      if (cfg_we && mSt[k] != 1) begin
         mTA[k][cfg_idx] = cfg_adr;
         mTD[k][cfg_idx] = cfg_data;
      end
      if (reset) begin
         mSt[k] = 0; mNact[k] = 0; mUsed[k] = '0; mMc[k] = 0;
         mCc[k] = 0; mCode[k] = 0; mFadr[k] = 0; mFdata[k] = 0;
         return;
      end
      if (mSt[k] != 1) begin
         if (start) begin
            n = (cfg_n > 3'd4) ? 4 : int'(cfg_n);
            mNact[k] = n; mUsed[k] = '0; mMc[k] = 0; mCc[k] = 0;
            mCode[k] = 0; mFadr[k] = 0; mFdata[k] = 0;
            mSt[k] = (n == 0) ? 2 : 1;
         end
         return;
      end
      cc = mCc[k];
      if (cc != 32'hFFFF_FFFF) mCc[k] = cc + 1;
      if (MemWrite) begin
         cand = -1;
         if (k != 1) cand = mMc[k];
         else begin
            for (int i = 0; i < mNact[k]; i++)
               if (!mUsed[k][i] && DataAdr == mTA[k][i]) begin
                  cand = i;
                  break;
               end
         end
         if (cand >= 0 && DataAdr == mTA[k][cand] && WriteData == mTD[k][cand]) begin
            mUsed[k][cand] = 1'b1;
            mMc[k]++;
            if (mMc[k] == mNact[k]) begin
               mSt[k] = 2;
               return;
            end
         end else if (DataAdr != 32'd96) begin
            mSt[k]    = 3;
            mCode[k]  = (cand >= 0 && DataAdr == mTA[k][cand]) ? 2 : 1;
            mFadr[k]  = DataAdr;
            mFdata[k] = WriteData;
            return;
         end
      end
      if (tout != 0 && cc == tout - 1) begin
         mSt[k] = 3; mCode[k] = 3; mFadr[k] = 0; mFdata[k] = 0;
      end
   endtask

   task automatic checkModel();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("dut%0d.done", k),      32'(doneO[k]),  32'(mSt[k] >= 2));
         chk($sformatf("dut%0d.pass", k),      32'(passO[k]),  32'(mSt[k] == 2));
         chk($sformatf("dut%0d.fail", k),      32'(failO[k]),  32'(mSt[k] == 3));
         chk($sformatf("dut%0d.fail_code", k), 32'(codeO[k]),  32'(mCode[k]));
         chk($sformatf("dut%0d.fail_adr", k),  fadrO[k],       mFadr[k]);
         chk($sformatf("dut%0d.fail_data", k), fdataO[k],      mFdata[k]);
         chk($sformatf("dut%0d.match_cnt", k), 32'(mcO[k]),    32'(mMc[k]));
         chk($sformatf("dut%0d.cycle_cnt", k), ccO[k],         mCc[k]);
      end
   endtask

   // One clock: model consumes the inputs the DUT samples, then outputs are compared.
   task automatic cyc();
      for (int k = 0; k < 3; k++) modelStep(k);
      @(posedge clk);
      #1;
      checkModel();
      reset = 1'b0; MemWrite = 1'b0; cfg_we = 1'b0; start = 1'b0;
   endtask

   task automatic setTbl(int i, logic [31:0] a, logic [31:0] d);
      cfg_we = 1'b1; cfg_idx = 2'(i); cfg_adr = a; cfg_data = d;
      cyc();
   endtask

   task automatic arm(int n);
      reset = 1'b1;
      cyc();
      cfg_n = 3'(n); start = 1'b1;
      cyc();
   endtask

   task automatic st(logic [31:0] a, logic [31:0] d);
      MemWrite = 1'b1; DataAdr = a; WriteData = d;
      cyc();
   endtask

   initial begin
      int sel, j;
      reset = 1'b1; MemWrite = 1'b0; cfg_we = 1'b0; start = 1'b0;
      DataAdr = '0; WriteData = '0; cfg_adr = '0; cfg_data = '0; cfg_idx = '0; cfg_n = '0;
      cyc();
      reset = 1'b1;
      cyc();
      chk("reset.done", 32'(doneO[0]), 0);
      chk("reset.match_cnt", 32'(mcO[0]), 0);

      setTbl(0, 100, 25); setTbl(1, 104, 9); setTbl(2, 108, 3); setTbl(3, 112, 4);

      // Scratch store ignored, then the single expected store passes.
      arm(1);
      st(96, 7);
      chk("scratch.fail", 32'(failO[0]), 0);
      st(100, 25);
      chk("single.pass", 32'(passO[0]), 1);
      chk("single.match_cnt", 32'(mcO[0]), 1);
      chk("single.fail_code", 32'(codeO[0]), 0);

      arm(1);
      st(100, 24);
      chk("dataMis.fail", 32'(failO[0]), 1);
      chk("dataMis.code", 32'(codeO[0]), 2);
      chk("dataMis.adr", fadrO[0], 100);
      chk("dataMis.data", fdataO[0], 24);

      vecs[0] = '{100, 25, 104,  9, 0, 2, 1, 0, 2, 1};
      vecs[1] = '{104,  9, 100, 25, 1, 0, 0, 0, 2, 1};
      vecs[2] = '{100, 25, 100, 25, 1, 1, 0, 1, 1, 0};
      vecs[3] = '{100, 26, 104,  9, 2, 0, 0, 2, 0, 0};
      vecs[4] = '{ 96,  1, 100, 25, 0, 1, 0, 0, 1, 0};
      vecs[5] = '{108,  3, 100, 25, 1, 0, 0, 1, 0, 0};
      vecs[6] = '{100, 25, 104,  8, 2, 1, 0, 2, 1, 0};
      vecs[7] = '{200,  5, 100, 25, 1, 0, 0, 1, 0, 0};
      vecs[8] = '{104,  9, 104,  9, 1, 0, 0, 1, 1, 0};
      for (int v = 0; v < 9; v++) begin
         arm(2);
         st(vecs[v].a0, vecs[v].d0);
         st(vecs[v].a1, vecs[v].d1);
         chk($sformatf("vec%0d.ordCode", v), 32'(codeO[0]), 32'(vecs[v].codeA));
         chk($sformatf("vec%0d.ordMc", v),   32'(mcO[0]),   32'(vecs[v].mcA));
         chk($sformatf("vec%0d.ordPass", v), 32'(passO[0]), 32'(vecs[v].passA));
         chk($sformatf("vec%0d.anyCode", v), 32'(codeO[1]), 32'(vecs[v].codeB));
         chk($sformatf("vec%0d.anyMc", v),   32'(mcO[1]),   32'(vecs[v].mcB));
         chk($sformatf("vec%0d.anyPass", v), 32'(passO[1]), 32'(vecs[v].passB));
      end

      // Timeout on the TIMEOUT=20 instance.
      arm(2);
      repeat (19) cyc();
      chk("tmo.before", 32'(failO[2]), 0);
      chk("tmo.ccBefore", ccO[2], 19);
      cyc();
      chk("tmo.code", 32'(codeO[2]), 3);
      chk("tmo.cycle_cnt", ccO[2], 20);
      chk("tmo.adr", fadrO[2], 0);

      // Completing store on the timeout edge wins.
      arm(1);
      repeat (19) cyc();
      st(100, 25);
      chk("tmoRace.pass", 32'(passO[2]), 1);
      chk("tmoRace.cycle_cnt", ccO[2], 20);

      // Reset two cycles after start, with a simultaneous start.
      arm(2);
      st(100, 25);
      reset = 1'b1; start = 1'b1; cfg_n = 3'd2;
      cyc();
      chk("midReset.done", 32'(doneO[0]), 0);
      chk("midReset.match_cnt", 32'(mcO[0]), 0);
      chk("midReset.cycle_cnt", ccO[0], 0);
      cyc();
      chk("midReset.stillIdle", ccO[0], 0);

      // Table writes while armed are dropped.
      arm(1);
      setTbl(0, 200, 1);
      st(100, 25);
      chk("armedWe.pass", 32'(passO[0]), 1);
      arm(1);
      st(100, 25);
      chk("armedWe.rerun", 32'(passO[0]), 1);

      arm(0);
      chk("zeroN.pass", 32'(passO[0]), 1);
      chk("zeroN.done", 32'(doneO[0]), 1);

      arm(7);
      st(100, 25); st(104, 9); st(108, 3); st(112, 4);
      chk("clamp.match_cnt", 32'(mcO[0]), 4);
      chk("clamp.pass", 32'(passO[0]), 1);

      // Randomised runs against the model.
      for (int r = 0; r < 60; r++) begin
         reset = 1'b1;
         cyc();
         for (int i = 0; i < 4; i++)
            setTbl(i, 100 + 4 * $urandom_range(0, 3), $urandom_range(0, 3));
         cfg_n = 3'($urandom_range(0, 6)); start = 1'b1;
         cyc();
         for (int c = 0; c < 25 && !(mSt[0] >= 2 && mSt[1] >= 2 && mSt[2] >= 2); c++) begin
            sel = $urandom_range(0, 9);
            MemWrite = ($urandom_range(0, 3) != 0);
            case (sel)
               0, 1, 2, 3: begin
                  j = (mMc[0] < 4) ? mMc[0] : 0;
                  DataAdr = mTA[0][j]; WriteData = mTD[0][j];
               end
               4, 5: begin
                  j = $urandom_range(0, 3);
                  DataAdr = mTA[1][j]; WriteData = mTD[1][j];
               end
               6: begin DataAdr = 96; WriteData = $urandom; end
               7: begin
                  j = $urandom_range(0, 3);
                  DataAdr = mTA[0][j]; WriteData = mTD[0][j] + 1;
               end
               8: begin DataAdr = $urandom_range(0, 255); WriteData = $urandom_range(0, 3); end
               default: begin
                  cfg_we = 1'b1; cfg_idx = 2'($urandom_range(0, 3));
                  cfg_adr = 100 + 4 * $urandom_range(0, 3); cfg_data = $urandom_range(0, 3);
                  cfg_n = 3'($urandom_range(0, 6)); start = 1'($urandom_range(0, 1));
               end
            endcase
            cyc();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
